sort_host: RTL and testbench

SORT_HOST -- requirements
Module: sort_host

---
 rtl/sort_pkg.sv | 19 +
 rtl/sort_order_check.sv | 31 +++
 rtl/sort_host.sv | 139 +++++++++++++
 tb/tb_sort_host.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the sort host: FSM state encoding and default sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sort_pkg;

    localparam int SORT_WIDTH   = 32;
    localparam int SORT_N       = 10;
    localparam int SORT_TIMEOUT = 256;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RSTS = 3'd1,
        SEND = 3'd2,
        WAIT = 3'd3,
        RECV = 3'd4,
        DONE = 3'd5
    } state_t;

endpackage

// File: rtl/sort_order_check.sv
// Sticky ascending-order checker over a stream of signed words.
// Latency: err rises on the same edge that samples the offending word.
// Backpressure: none; samples whenever chk_vld is high.
module sort_order_check #(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    chk_vld,
    input  logic                    first,
    input  logic signed [WIDTH-1:0] dat,
    output logic                    err
);

    logic signed [WIDTH-1:0] prev;

    // Remember the previous word; flag any strict decrease (equal neighbours are fine).
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err  <= 1'b0;
            prev <= '0;
        end else if (chk_vld) begin
            prev <= dat;
            if (!first && (dat < prev)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sort_host.sv
// Batches N signed words, streams them to a serial sorter, captures and order-checks the result.
// Latency: start_i to done_o = 2N + 3 + W cycles, W = cycles spent waiting for sort_ready_i.
// Backpressure: load_ready_o low when buffer full or busy; sorter ready bounded by TIMEOUT.
module sort_host
    import sort_pkg::*;
#(
    parameter int WIDTH   = SORT_WIDTH,
    parameter int N       = SORT_N,
    parameter int TIMEOUT = SORT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid_i,
    input  logic signed [WIDTH-1:0] load_data_i,
    output logic                    load_ready_o,
    input  logic                    start_i,
    output logic                    sort_rst_o,
    output logic signed [WIDTH-1:0] sort_data_o,
    input  logic                    sort_ready_i,
    input  logic signed [WIDTH-1:0] sort_data_i,
    output logic                    res_valid_o,
    output logic signed [WIDTH-1:0] res_data_o,
    output logic [$clog2(N)-1:0]    res_idx_o,
    output logic                    done_o,
    output logic                    order_err_o,
    output logic                    timeout_o
);

    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(N);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(N);
    localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);

    state_t                  state, state_nxt;
    logic [CW-1:0]           count;
    logic [IW-1:0]           idx;
    logic [TW-1:0]           wait_cnt;
    logic signed [WIDTH-1:0] buf_mem [N];
    logic                    load_acc;
    logic                    capture;
    logic                    wait_expire;

    assign load_acc    = load_valid_i && load_ready_o;
    assign capture     = ((state == WAIT) && sort_ready_i) || (state == RECV);
    assign wait_expire = (state == WAIT) && !sort_ready_i && (wait_cnt == LAST_WAIT);

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nxt    = state;
        load_ready_o = 1'b0;
        sort_rst_o   = 1'b0;
        sort_data_o  = '0;
        case (state)
            IDLE: begin
                load_ready_o = (count < FULL_CNT);
                if (start_i && (count == FULL_CNT)) state_nxt = RSTS;
            end
            RSTS: begin
                sort_rst_o = 1'b1;
                state_nxt  = SEND;
            end
            SEND: begin
                sort_data_o = buf_mem[idx];
                if (idx == LAST_IDX) state_nxt = WAIT;
            end
            WAIT: begin
                if (sort_ready_i)     state_nxt = RECV;
                else if (wait_expire) state_nxt = IDLE;
            end
            RECV: begin
                if (idx == LAST_IDX) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, fill count, word index and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            idx      <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (load_acc)                           count <= count + 1'b1;
            else if ((state == DONE) || wait_expire) count <= '0;
            case (state)
                SEND:    idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                WAIT:    idx <= sort_ready_i ? IW'(1) : '0;
                RECV:    idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                default: idx <= '0;
            endcase
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
        end
    end

    // Batch buffer; contents are don't-care until loaded, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && load_acc) begin
            buf_mem[count] <= load_data_i;
        end
    end

    // Registered result stream and completion/timeout pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
            res_idx_o   <= '0;
            done_o      <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            res_valid_o <= capture;
            if (capture) begin
                res_data_o <= sort_data_i;
                res_idx_o  <= (state == WAIT) ? '0 : idx;
            end
            done_o    <= (state == DONE);
            timeout_o <= wait_expire;
        end
    end

    sort_order_check #(
        .WIDTH (WIDTH)
    ) u_order_check (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == RSTS),
        .chk_vld (capture),
        .first   (state == WAIT),
        .dat     (sort_data_i),
        .err     (order_err_o)
    );

endmodule

// File: tb/tb_sort_host.sv
module tb_sort_host;

    localparam int W  = 32;
    localparam int N  = 10;
    localparam int TO = 256;

    logic                clk = 1'b0;
    logic                rst;
    logic                load_valid_i;
    logic signed [W-1:0] load_data_i;
    logic                load_ready_o;
    logic                start_i;
    logic                sort_rst_o;
    logic signed [W-1:0] sort_data_o;
    logic                sort_ready_i;
    logic signed [W-1:0] sort_data_i;
    logic                res_valid_o;
    logic signed [W-1:0] res_data_o;
    logic [3:0]          res_idx_o;
    logic                done_o;
    logic                order_err_o;
    logic                timeout_o;

    sort_host #(.WIDTH(W), .N(N), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid_i (load_valid_i),
        .load_data_i  (load_data_i),
        .load_ready_o (load_ready_o),
        .start_i      (start_i),
        .sort_rst_o   (sort_rst_o),
        .sort_data_o  (sort_data_o),
        .sort_ready_i (sort_ready_i),
        .sort_data_i  (sort_data_i),
        .res_valid_o  (res_valid_o),
        .res_data_o   (res_data_o),
        .res_idx_o    (res_idx_o),
        .done_o       (done_o),
        .order_err_o  (order_err_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic signed [W-1:0] d;
        logic [3:0]          idx;
        logic                err;
    } exp_t;

    exp_t                sb[$];
    exp_t                mon_e;
    int                  tests    = 0;
    int                  fails    = 0;
    int                  done_cnt = 0;
    logic signed [W-1:0] ld  [N];
    logic signed [W-1:0] ret [N];

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop expected result whenever the DUT presents one.
    always @(negedge clk) begin
        if (rst === 1'b0 && done_o === 1'b1) done_cnt++;
        if (rst === 1'b0 && res_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                check("res_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("res_data", res_data_o, mon_e.d);
                check("res_idx", res_idx_o, mon_e.idx);
                check("order_err_at_capture", order_err_o, mon_e.err);
            end
        end
    end

    task automatic load_all();
        for (int i = 0; i < N; i++) begin
            load_valid_i = 1'b1;
            load_data_i  = ld[i];
            tick();
        end
        load_valid_i = 1'b0;
    endtask

    // Start the loaded batch; sorter model waits w cycles then returns ret[].
    task automatic run_batch(input int w, input logic err_final);
        int                  cyc;
        int                  k;
        int                  dc;
        logic                e;
        logic signed [W-1:0] prev;
        dc = done_cnt;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        cyc = 1;
        check("sort_rst_pulse", sort_rst_o, 1);
        check("load_ready_busy", load_ready_o, 0);
        tick(); cyc++;
        check("sort_rst_one_cycle", sort_rst_o, 0);
        check("order_err_cleared_rsts", order_err_o, 0);
        for (int i = 0; i < N; i++) begin
            check("sort_data_send", sort_data_o, ld[i]);
            tick(); cyc++;
        end
        check("sort_data_zero_wait", sort_data_o, 0);
        for (int j = 0; j < w; j++) begin
            sort_ready_i = 1'b0;
            sort_data_i  = 77;
            tick(); cyc++;
        end
        e    = 1'b0;
        prev = '0;
        for (int i = 0; i < N; i++) begin
            sort_ready_i = (i == 0);
            sort_data_i  = ret[i];
            if (i > 0 && ret[i] < prev) e = 1'b1;
            prev = ret[i];
            sb.push_back('{ret[i], 4'(i), e});
            tick(); cyc++;
        end
        sort_ready_i = 1'b0;
        sort_data_i  = '0;
        k = 0;
        while (done_o !== 1'b1 && k < 20) begin
            tick(); cyc++; k++;
        end
        if (done_o !== 1'b1) check("done_wait_expired", 0, 1);
        else                 check("done_latency", cyc, 2 * N + w + 3);
        check("order_err_final", order_err_o, err_final);
        tick();
        check("done_one_cycle", done_o, 0);
        check("done_count", done_cnt, dc + 1);
        check("idle_load_ready", load_ready_o, 1);
        check("scoreboard_empty", sb.size(), 0);
    endtask

    initial begin
        int c;
        int dc;
        rst          = 1'b1;
        load_valid_i = 1'b0;
        load_data_i  = '0;
        start_i      = 1'b0;
        sort_ready_i = 1'b0;
        sort_data_i  = '0;
        tick(); tick();
        check("rst_load_ready", load_ready_o, 1);
        check("rst_sort_rst", sort_rst_o, 0);
        check("rst_res_valid", res_valid_o, 0);
        check("rst_order_err", order_err_o, 0);
        rst = 1'b0;
        tick();

        // Basic batch with start-before-full and overfill corner cases.
        ld  = '{5, -3, 9, 0, 7, -8, 2, 2, 100, -1};
        ret = '{-8, -3, -1, 0, 2, 2, 5, 7, 9, 100};
        for (int i = 0; i < N - 1; i++) begin
            load_valid_i = 1'b1;
            load_data_i  = ld[i];
            tick();
        end
        load_valid_i = 1'b0;
        start_i = 1'b1;
        tick();
        check("start_9_ignored", sort_rst_o, 0);
        check("start_9_ready", load_ready_o, 1);
        load_valid_i = 1'b1;
        load_data_i  = ld[N-1];
        tick();
        start_i = 1'b0;
        check("load_start_same_cycle", sort_rst_o, 0);
        check("full_not_ready", load_ready_o, 0);
        load_data_i = 555;
        tick();
        load_valid_i = 1'b0;
        check("overfill_no_start", sort_rst_o, 0);
        check("overfill_not_ready", load_ready_o, 0);
        run_batch(3, 1'b0);

        // Out-of-order sorter output.
        ld  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        ret = '{1, 2, 4, 3, 5, 6, 7, 8, 9, 10};
        load_all();
        run_batch(0, 1'b1);

        // Extreme signed values returned ascending; also clears the sticky error.
        ld  = '{32'sh7FFFFFFF, -1, 0, 1, 32'sh80000000, 32'sh80000000, 32'sh7FFFFFFF, 32'sh80000001, 32'sh7FFFFFFE, 32'sh7FFFFFFF};
        ret = '{32'sh80000000, 32'sh80000000, 32'sh80000001, -1, 0, 1, 32'sh7FFFFFFE, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF};
        load_all();
        run_batch(1, 1'b0);

        // Reset in the middle of SEND.
        ld = '{11, 12, 13, 14, 15, 16, 17, 18, 19, 20};
        load_all();
        dc = done_cnt;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        check("send_word4", sort_data_o, 15);
        rst = 1'b1;
        tick();
        check("midrst_load_ready", load_ready_o, 1);
        check("midrst_sort_data", sort_data_o, 0);
        check("midrst_sort_rst", sort_rst_o, 0);
        check("midrst_res_valid", res_valid_o, 0);
        check("midrst_done", done_o, 0);
        check("midrst_timeout", timeout_o, 0);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            check("midrst_count_ready", load_ready_o, 1);
            load_valid_i = 1'b1;
            load_data_i  = ld[i];
            tick();
        end
        load_valid_i = 1'b0;
        check("midrst_count_full", load_ready_o, 0);
        check("midrst_no_done", done_cnt, dc);

        // Sorter never ready: timeout from the buffer refilled above.
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        for (int i = 0; i < N; i++) tick();
        c = 0;
        while (timeout_o !== 1'b1 && c < 400) begin
            tick(); c++;
        end
        check("timeout_latency", c, TO);
        check("timeout_load_ready", load_ready_o, 1);
        check("timeout_no_done", done_cnt, dc);
        tick();
        check("timeout_one_cycle", timeout_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
